rx_lane_controller: RTL
=======================

// Module: rx_lane_controller
// PURPOSE
//  Receive-side lane controller for the Aurora 8b/10b link; counterpart of the TX lane controller.
//  Takes decoded symbols + K-flags from the 8b/10b decoders, acquires lane lock on /K/ commas,
//  flags ordered sets (/K/ /R/ /A/), strips them, reassembles data bytes into DATA_W-bit words.
//  Single-lane mode: one byte/cycle from the selected lane. Multi-lane mode: one byte/lane/cycle.
// PARAMETERS
//  N_LANES   4   number of physical lanes
//  SYM_W     8   decoded symbol width (encoder data-in size)
//  DATA_W    32  reassembled word width; DATA_W == N_LANES*SYM_W
//  LOCK_CNT  4   consecutive /K/ needed to declare lock (>=1)
// PORTS
//  clk          in   1                single clock, all logic on posedge
//  rst_n        in   1                asynchronous, active-low reset
//  single_lane  in   1                1: use lane_select only; 0: all lanes bonded
//  lane_select  in   $clog2(N_LANES)  active lane in single-lane mode
//  ctrl_in      in   N_LANES          per-lane K-flag from decoder (1 = control symbol)
//  data_in      in   N_LANES*SYM_W    per-lane decoded symbol, lane i at [i*SYM_W +: SYM_W]
//  lane_up      out  1                1 while state == LOCKED
//  os_k/os_r/os_a out 1 each          1-cycle pulse: /K/ (BC), /R/ (1C), /A/ (7C) received
//  data_out     out  DATA_W           reassembled word, first/lane-0 byte in MSBs
//  data_valid   out  1                1-cycle pulse, data_out valid
//  rx_err       out  1                1-cycle pulse: unknown K-code or fragmented word
//  err_count    out  16               error counter (see CONFIGURATION)
// BEHAVIOUR
//  - Reset (async assert, sync release): all outputs 0, state UNLOCKED, byte index 0, lock counter 0.
//  - "Active lanes": single_lane=1 -> lane_select only; single_lane=0 -> all N_LANES, same cycle.
//  - FSM: UNLOCKED -> LOCKING on /K/ on all active lanes; LOCKING counts consecutive such cycles;
//    non-/K/ cycle -> UNLOCKED, counter 0; count reaches LOCK_CNT -> LOCKED (lane_up=1 next cycle).
//    LOCKED -> UNLOCKED on unknown K-code (ctrl=1, code not BC/1C/7C) on any active lane.
//  - Latency: symbol sampled at edge n -> os_*/rx_err/data_valid registered, visible after edge n+1.
//  - os_* pulse in any state when all active lanes carry that code; mixed K-codes across bonded
//    lanes in LOCKED -> rx_err, no os_* pulse, state unchanged.
//  - Data (LOCKED only; ctrl=0 ignored otherwise):
//    single-lane: byte i of word stored at data_out[DATA_W-1-i*SYM_W -: SYM_W]; after byte
//    N_LANES-1 data_valid pulses, index wraps to 0. Ordered sets between bytes of a word: /K/ /R/ /A/
//    pause assembly (index held), never emit data. Changing lane_select mid-word -> index 0, no error.
//    multi-lane: all lanes ctrl=0 -> word {lane0..laneN-1} emitted, data_valid same latency.
//    Some lanes ctrl=0, others ctrl=1 -> rx_err, no data_valid.
//  - Fragment: LOCKED->UNLOCKED with index != 0 -> partial word discarded, rx_err pulse (one only,
//    even if also caused by unknown K-code).
//  - data_out holds last valid word between pulses; cleared only by reset.
//  - Reset mid-word/mid-lock: immediate return to reset state, no pulse emitted.
// CONFIGURATION
//  RX_ERR_CNT_EN defined: err_count increments on every rx_err pulse, saturates at 16'hFFFF,
//    cleared by reset only. Undefined: counter logic omitted, err_count tied to 16'h0000.
// TESTING
//  1 single_lane=1, lane_select=2, 4x {ctrl=1,BC} -> lane_up=1 after 5th edge; os_k 4 pulses.
//  2 locked single-lane, bytes 11,22,BC(K),33,44 -> one data_valid, data_out=32'h11223344, os_k=1.
//  3 single_lane=0 locked, lanes0..3 = AA,BB,CC,DD ctrl=0 -> data_out=32'hAABBCCDD, 1 cycle later.
//  4 locked, lane_select lane ctrl=1 code 0x3C -> rx_err pulse, lane_up=0; with RX_ERR_CNT_EN err_count=1.
//  5 3x /K/ then data byte 55 (LOCK_CNT=4) -> stays UNLOCKED, no data_valid, counter restarts.
//  6 rst_n low after 2 bytes of a word -> all outputs 0 immediately; relock + 4 new bytes -> clean word.

Source files
------------

// File: rtl/rx_lane_controller.sv
// Receive-side lane controller for the Aurora 8b/10b link.
// Acquires lane lock on /K/ commas, flags /K/ /R/ /A/ ordered sets, strips them and reassembles
// decoded bytes into DATA_W-bit words (single-lane: one byte per cycle, bonded: one per lane).
// Inputs are registered once, then decoded; every pulse output is registered again, so a
// symbol sampled at edge n shows up after edge n+1.
// Optional feature: define RX_ERR_CNT_EN to get a saturating rx_err counter on err_count.
module rx_lane_controller #(
   parameter int unsigned N_LANES  = 4,
   parameter int unsigned SYM_W    = 8,
   parameter int unsigned DATA_W   = 32,  // must equal N_LANES*SYM_W
   parameter int unsigned LOCK_CNT = 4    // >= 1
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         single_lane,
   input  logic [$clog2(N_LANES)-1:0]   lane_select,
   input  logic [N_LANES-1:0]           ctrl_in,
   input  logic [N_LANES*SYM_W-1:0]     data_in,
   output logic                         lane_up,
   output logic                         os_k,
   output logic                         os_r,
   output logic                         os_a,
   output logic [DATA_W-1:0]            data_out,
   output logic                         data_valid,
   output logic                         rx_err,
   output logic [15:0]                  err_count
);

   localparam int unsigned SEL_W = $clog2(N_LANES);
   localparam int unsigned CNT_W = $clog2(LOCK_CNT + 1);
   localparam logic [SYM_W-1:0] K_CODE = SYM_W'(8'hBC);
   localparam logic [SYM_W-1:0] R_CODE = SYM_W'(8'h1C);
   localparam logic [SYM_W-1:0] A_CODE = SYM_W'(8'h7C);

   typedef enum logic [1:0] {StUnlocked, StLocking, StLocked} state_e;

   state_e                   state_q, state_d;
   logic [CNT_W-1:0]         lock_cnt_q, lock_cnt_d, lock_cnt_inc;
   logic                     single_q;
   logic [SEL_W-1:0]         sel_q, sel_prev_q;
   logic [N_LANES-1:0]       ctrl_q;
   logic [N_LANES*SYM_W-1:0] data_q;
   logic [SEL_W-1:0]         idx_q, idx_d, idx_eff;
   logic [DATA_W-1:0]        word_q, word_d, data_out_q, data_out_d, multi_word;
   logic                     os_k_q, os_k_d, os_r_q, os_r_d, os_a_q, os_a_d;
   logic                     data_valid_q, data_valid_d, rx_err_q, rx_err_d;
   logic                     all_k, all_r, all_a, any_ctrl, any_unknown, locked, sel_changed;
   logic                     act;
   logic [SYM_W-1:0]         sym, lane_byte;

   // Input sampling stage
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         single_q   <= 1'b0;
         sel_q      <= '0;
         sel_prev_q <= '0;
         ctrl_q     <= '0;
         data_q     <= '0;
      end else begin
         single_q   <= single_lane;
         sel_q      <= lane_select;
         sel_prev_q <= sel_q;
         ctrl_q     <= ctrl_in;
         data_q     <= data_in;
      end
   end

   // Per-lane symbol decode, reduced over the active lanes
   always_comb begin
      all_k       = 1'b1;
      all_r       = 1'b1;
      all_a       = 1'b1;
      any_ctrl    = 1'b0;
      any_unknown = 1'b0;
      multi_word  = '0;
      lane_byte   = '0;
      sym         = '0;
      act         = 1'b0;
      for (int i = 0; i < N_LANES; i++) begin
         sym = data_q[i*SYM_W +: SYM_W];
         act = !single_q || (sel_q == SEL_W'(i));
         multi_word[DATA_W-1-i*SYM_W -: SYM_W] = sym;
         if (sel_q == SEL_W'(i)) lane_byte = sym;
         if (act) begin
            if (!ctrl_q[i] || sym != K_CODE) all_k = 1'b0;
            if (!ctrl_q[i] || sym != R_CODE) all_r = 1'b0;
            if (!ctrl_q[i] || sym != A_CODE) all_a = 1'b0;
            if (ctrl_q[i]) begin
               any_ctrl = 1'b1;
               if (sym != K_CODE && sym != R_CODE && sym != A_CODE) any_unknown = 1'b1;
            end
         end
      end
   end

   // Lock FSM state register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= StUnlocked;
         lock_cnt_q <= '0;
      end else begin
         state_q    <= state_d;
         lock_cnt_q <= lock_cnt_d;
      end
   end

   assign lock_cnt_inc = lock_cnt_q + CNT_W'(1);

   // Lock FSM next state; UNLOCKED and LOCKING share the /K/ counting path
   always_comb begin
      state_d    = state_q;
      lock_cnt_d = lock_cnt_q;
      unique case (state_q)
         StUnlocked, StLocking: begin
            if (all_k) begin
               lock_cnt_d = lock_cnt_inc;
               state_d    = (lock_cnt_inc == CNT_W'(LOCK_CNT)) ? StLocked : StLocking;
            end else begin
               lock_cnt_d = '0;
               state_d    = StUnlocked;
            end
         end
         StLocked: begin
            if (any_unknown) begin
               lock_cnt_d = '0;
               state_d    = StUnlocked;
            end
         end
         default: begin
            lock_cnt_d = '0;
            state_d    = StUnlocked;
         end
      endcase
   end

   assign locked      = (state_q == StLocked);
   assign sel_changed = single_q && (sel_q != sel_prev_q);
   assign idx_eff     = sel_changed ? '0 : idx_q;

   // Output/datapath next values: ordered-set pulses, word assembly, error pulses
   always_comb begin
      os_k_d       = all_k;
      os_r_d       = all_r;
      os_a_d       = all_a;
      data_valid_d = 1'b0;
      rx_err_d     = 1'b0;
      idx_d        = idx_eff;
      word_d       = word_q;
      data_out_d   = data_out_q;
      if (!locked) begin
         idx_d = '0;
      end else if (any_unknown) begin
         // Covers the fragment case too: a single pulse whether or not a word was in flight
         rx_err_d = 1'b1;
         idx_d    = '0;
      end else if (!any_ctrl) begin
         if (single_q) begin
            word_d[DATA_W-1-int'(idx_eff)*SYM_W -: SYM_W] = lane_byte;
            if (idx_eff == SEL_W'(N_LANES - 1)) begin
               data_out_d   = word_d;
               data_valid_d = 1'b1;
               idx_d        = '0;
            end else begin
               idx_d = idx_eff + SEL_W'(1);
            end
         end else begin
            data_out_d   = multi_word;
            data_valid_d = 1'b1;
            idx_d        = '0;
         end
      end else if (!(all_k || all_r || all_a)) begin
         // Bonded lanes disagree (mixed K-codes or mixed control/data)
         rx_err_d = 1'b1;
      end
   end

   // Datapath and pulse registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         idx_q        <= '0;
         word_q       <= '0;
         data_out_q   <= '0;
         os_k_q       <= 1'b0;
         os_r_q       <= 1'b0;
         os_a_q       <= 1'b0;
         data_valid_q <= 1'b0;
         rx_err_q     <= 1'b0;
      end else begin
         idx_q        <= idx_d;
         word_q       <= word_d;
         data_out_q   <= data_out_d;
         os_k_q       <= os_k_d;
         os_r_q       <= os_r_d;
         os_a_q       <= os_a_d;
         data_valid_q <= data_valid_d;
         rx_err_q     <= rx_err_d;
      end
   end

`ifdef RX_ERR_CNT_EN
   logic [15:0] err_cnt_q;

   // Saturating error counter, stepped alongside the rx_err pulse it counts
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_cnt_q <= '0;
      end else if (rx_err_d && err_cnt_q != 16'hFFFF) begin
         err_cnt_q <= err_cnt_q + 16'd1;
      end
   end

   assign err_count = err_cnt_q;
`else
   assign err_count = 16'h0000;
`endif

   assign lane_up    = locked;
   assign os_k       = os_k_q;
   assign os_r       = os_r_q;
   assign os_a       = os_a_q;
   assign data_out   = data_out_q;
   assign data_valid = data_valid_q;
   assign rx_err     = rx_err_q;

endmodule
